bytes_to_bits_seq: RTL and testbench

//  Sequencer for the Kyber BytesToBits conversion. On start, reads BYTE_COUNT bytes from a byte

---
 rtl/bytes_to_bits_if.sv | 24 ++
 rtl/bytes_to_bits_seq.sv | 97 +++++++++
 tb/tb_bytes_to_bits_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bytes_to_bits_if.sv
// bytes_to_bits_if: control, byte-buffer read port and bit stream of bytes_to_bits_seq
interface bytes_to_bits_if #(
  parameter int ADDR_W = 8,
  parameter int OUT_W = 1
);
  logic start;
  logic busy;
  logic done;
  logic mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic bit_valid;
  logic bit_ready;
  logic [OUT_W-1:0] bit_data;
  logic bit_last;
  modport master (
    input start, mem_rd_data, bit_ready,
    output busy, done, mem_rd_en, mem_rd_addr, bit_valid, bit_data, bit_last
  );
  modport slave (
    output start, mem_rd_data, bit_ready,
    input busy, done, mem_rd_en, mem_rd_addr, bit_valid, bit_data, bit_last
  );
endinterface

// File: rtl/bytes_to_bits_seq.sv
// bytes_to_bits_seq: Kyber BytesToBits sequencer, byte buffer to LSB-first bit stream; define BTB_PREFETCH_EN for a gap-free prefetching build
module bytes_to_bits_seq #(
  parameter int BYTE_COUNT = 256,
  parameter int ADDR_W = 8,
  parameter int OUT_W = 1
) (
  input logic clk,
  input logic rst,
  bytes_to_bits_if.master io
);
  localparam int N = 8 / OUT_W;
  localparam int BW = $clog2(N) + 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] byte_idx;
  logic [BW-1:0] beat;
  logic [7:0] sh;
  logic fire;
  logic last_beat;
  logic last_byte;
  assign fire = io.bit_valid && io.bit_ready;
  assign last_beat = beat == BW'(N - 1);
  assign last_byte = byte_idx == ADDR_W'(BYTE_COUNT - 1);
  assign io.busy = state inside {FETCH, WAIT, SHIFT};
  assign io.done = state == DONE;
  assign io.bit_valid = state == SHIFT;
  assign io.bit_data = sh[OUT_W-1:0];
  assign io.bit_last = io.bit_valid && last_byte && last_beat;
`ifdef BTB_PREFETCH_EN
  // rd_q marks read data on the bus this cycle; pf holds one byte fetched ahead of sh.
  // A new read is issued only when, after this edge, no fetched byte is left waiting,
  // so returning data always has room in sh or pf.
  logic [ADDR_W:0] rd_ptr;
  logic rd_q;
  logic pf_v;
  logic [7:0] pf;
  logic load_sh;
  logic held_z;
  assign load_sh = state == WAIT || (fire && last_beat);
  assign held_z = {1'b0, pf_v} + {1'b0, rd_q} <= {1'b0, load_sh};
  assign io.mem_rd_en = state == FETCH || ((state == WAIT || state == SHIFT) && held_z && rd_ptr != (ADDR_W+1)'(BYTE_COUNT));
  assign io.mem_rd_addr = rd_ptr[ADDR_W-1:0];
`else
  assign io.mem_rd_en = state == FETCH;
  assign io.mem_rd_addr = byte_idx;
`endif
  // Sequencer FSM, byte/beat counters and output shift register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      byte_idx <= '0;
      beat <= '0;
      sh <= '0;
`ifdef BTB_PREFETCH_EN
      rd_ptr <= '0;
      rd_q <= 1'b0;
      pf_v <= 1'b0;
      pf <= '0;
`endif
    end else begin
      if (fire) begin
        beat <= last_beat ? '0 : beat + BW'(1);
        sh <= sh >> OUT_W;
      end
`ifdef BTB_PREFETCH_EN
      rd_q <= io.mem_rd_en;
      if (io.mem_rd_en) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      if (rd_q && (pf_v || !load_sh)) pf <= io.mem_rd_data;
      if (state == WAIT || state == SHIFT) pf_v <= !held_z;
`endif
      case (state)
        IDLE: if (io.start) state <= FETCH;
        FETCH: state <= WAIT;
        WAIT: begin
          sh <= io.mem_rd_data;
          state <= SHIFT;
        end
        SHIFT: if (fire && last_beat) begin
          if (!last_byte) byte_idx <= byte_idx + ADDR_W'(1);
`ifdef BTB_PREFETCH_EN
          state <= last_byte ? DONE : SHIFT;
          if (!last_byte) sh <= pf_v ? pf : io.mem_rd_data;
`else
          state <= last_byte ? DONE : FETCH;
`endif
        end
        default: begin
          state <= IDLE;
          byte_idx <= '0;
`ifdef BTB_PREFETCH_EN
          rd_ptr <= '0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bytes_to_bits_seq.sv
// tb_bytes_to_bits_seq: directed self-checking bench for bytes_to_bits_seq with OUT_W=1 and OUT_W=8 instances
module tb_bytes_to_bits_seq;
  localparam int BC = 256;
`ifdef BTB_PREFETCH_EN
  localparam int T1 = 3 + 8 * BC;
  localparam int T8 = 3 + BC;
`else
  localparam int T1 = BC * (2 + 8) + 1;
  localparam int T8 = BC * (2 + 1) + 1;
`endif
  logic clk = 0;
  logic rst = 0;
  logic clr = 0;
  always #5 clk = ~clk;
  bytes_to_bits_if #(.ADDR_W(8), .OUT_W(1)) a ();
  bytes_to_bits_if #(.ADDR_W(8), .OUT_W(8)) b ();
  bytes_to_bits_seq #(.BYTE_COUNT(BC), .ADDR_W(8), .OUT_W(1)) dut1 (.clk(clk), .rst(rst), .io(a.master));
  bytes_to_bits_seq #(.BYTE_COUNT(BC), .ADDR_W(8), .OUT_W(8)) dut8 (.clk(clk), .rst(rst), .io(b.master));
  logic [7:0] m1 [BC];
  logic [7:0] m8 [BC];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int st1, st8;
  always @(posedge clk) cyc <= cyc + 1;
  // Synchronous byte buffers, one-cycle read latency
  always @(posedge clk) begin
    if (a.mem_rd_en) a.mem_rd_data <= m1[a.mem_rd_addr];
    if (b.mem_rd_en) b.mem_rd_data <= m8[b.mem_rd_addr];
  end
  // Monitor for the OUT_W=1 instance: reads, done, stream, last position and hold-while-stalled
  bit s1 [$];
  int rd1, bad1, dn1, dcyc1, ln1, lat1, lcyc1, stab1, stall1;
  logic hv1, hd1, hl1;
  always @(posedge clk) begin
    if (clr) begin
      s1.delete();
      rd1 <= 0;
      bad1 <= 0;
      dn1 <= 0;
      ln1 <= 0;
      stab1 <= 0;
      stall1 <= 0;
      hv1 <= 0;
    end else begin
      if (a.mem_rd_en) begin
        if (a.mem_rd_addr != 8'(rd1)) bad1 <= bad1 + 1;
        rd1 <= rd1 + 1;
      end
      if (a.done) begin
        dn1 <= dn1 + 1;
        dcyc1 <= cyc;
      end
      if (hv1 && (!a.bit_valid || a.bit_data[0] != hd1 || a.bit_last != hl1)) stab1 <= stab1 + 1;
      if (a.bit_valid && !a.bit_ready) stall1 <= stall1 + 1;
      hv1 <= a.bit_valid && !a.bit_ready;
      hd1 <= a.bit_data[0];
      hl1 <= a.bit_last;
      if (a.bit_valid && a.bit_ready) begin
        if (a.bit_last) begin
          ln1 <= ln1 + 1;
          lat1 <= s1.size();
          lcyc1 <= cyc;
        end
        s1.push_back(a.bit_data[0]);
      end
    end
  end
  // Monitor for the OUT_W=8 instance
  logic [7:0] s8 [$];
  int rd8, bad8, dn8, dcyc8, ln8, lat8;
  always @(posedge clk) begin
    if (clr) begin
      s8.delete();
      rd8 <= 0;
      bad8 <= 0;
      dn8 <= 0;
      ln8 <= 0;
    end else begin
      if (b.mem_rd_en) begin
        if (b.mem_rd_addr != 8'(rd8)) bad8 <= bad8 + 1;
        rd8 <= rd8 + 1;
      end
      if (b.done) begin
        dn8 <= dn8 + 1;
        dcyc8 <= cyc;
      end
      if (b.bit_valid && b.bit_ready) begin
        if (b.bit_last) begin
          ln8 <= ln8 + 1;
          lat8 <= s8.size();
        end
        s8.push_back(b.bit_data);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic clear();
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask
  task automatic go1();
    @(negedge clk);
    a.start = 1;
    st1 = cyc;
    @(negedge clk);
    a.start = 0;
  endtask
  task automatic go8();
    @(negedge clk);
    b.start = 1;
    st8 = cyc;
    @(negedge clk);
    b.start = 0;
  endtask
  task automatic wait_done1(input int lim);
    int k = 0;
    while (!a.done && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("done1_seen", 32'(a.done), 1);
  endtask
  task automatic wait_done8(input int lim);
    int k = 0;
    while (!b.done && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("done8_seen", 32'(b.done), 1);
  endtask
  initial begin
    int mism;
    a.start = 0;
    b.start = 0;
    a.bit_ready = 1;
    b.bit_ready = 1;
    for (int i = 0; i < BC; i++) begin
      m1[i] = 8'h00;
      m8[i] = 8'(i);
    end
    m1[0] = 8'h01;
    m1[1] = 8'h80;
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_outs1", 32'({a.busy, a.done, a.mem_rd_en, a.mem_rd_addr, a.bit_valid, a.bit_data, a.bit_last}), 0);
    chk("rst_outs8", 32'({b.busy, b.done, b.mem_rd_en, b.mem_rd_addr, b.bit_valid, b.bit_data, b.bit_last}), 0);
    rst = 1;
    clear();
    // start latency and OUT_W=1 stream of 0x01,0x80,0...
    @(negedge clk);
    a.start = 1;
    st1 = cyc;
    @(negedge clk);
    a.start = 0;
    chk("lat_fetch_valid", 32'(a.bit_valid), 0);
    chk("lat_fetch_busy", 32'(a.busy), 1);
    chk("lat_fetch_rd_en", 32'(a.mem_rd_en), 1);
    @(negedge clk);
    chk("lat_wait_valid", 32'(a.bit_valid), 0);
    @(negedge clk);
    chk("lat_shift_valid", 32'(a.bit_valid), 1);
    chk("first_bit", 32'(a.bit_data), 1);
    wait_done1(4000);
    @(negedge clk);
    chk("t2_len", 32'(s1.size()), 2048);
    chk("t2_bit0", 32'(s1[0]), 1);
    chk("t2_bit15", 32'(s1[15]), 1);
    mism = 0;
    for (int k = 1; k < 2048; k++) if (k != 15 && s1[k] != 1'b0) mism++;
    chk("t2_zero_bits", 32'(mism), 0);
    chk("t2_last_idx", 32'(lat1), 2047);
    chk("t2_last_cnt", 32'(ln1), 1);
    chk("t2_done_after_last", 32'(dcyc1 - lcyc1), 1);
    chk("t2_done_cnt", 32'(dn1), 1);
    chk("t2_reads", 32'(rd1), 256);
    chk("t2_read_order", 32'(bad1), 0);
    chk("t2_cycles", 32'(dcyc1 - st1), 32'(T1));
    chk("t2_idle_busy", 32'(a.busy), 0);
    // OUT_W=8 counting pattern
    clear();
    go8();
    wait_done8(2000);
    @(negedge clk);
    chk("t3_len", 32'(s8.size()), 256);
    mism = 0;
    for (int k = 0; k < 256; k++) if (s8[k] != 8'(k)) mism++;
    chk("t3_stream", 32'(mism), 0);
    chk("t3_last_byte", 32'(s8[255]), 32'hff);
    chk("t3_last_idx", 32'(lat8), 255);
    chk("t3_last_cnt", 32'(ln8), 1);
    chk("t3_done_cnt", 32'(dn8), 1);
    chk("t3_reads", 32'(rd8), 256);
    chk("t3_read_order", 32'(bad8), 0);
    chk("t3_cycles", 32'(dcyc8 - st8), 32'(T8));
    // random backpressure on the OUT_W=1 instance against a BytesToBits model
    for (int i = 0; i < BC; i++) m1[i] = 8'((i * 37) % 256);
    clear();
    go1();
    for (int k = 0; k < 12000 && !a.done; k++) begin
      @(negedge clk);
      a.bit_ready = 1'($urandom_range(0, 1));
    end
    chk("t4_done_seen", 32'(a.done), 1);
    a.bit_ready = 1;
    @(negedge clk);
    chk("t4_len", 32'(s1.size()), 2048);
    mism = 0;
    for (int k = 0; k < 2048; k++) if (s1[k] != m1[k / 8][k % 8]) mism++;
    chk("t4_stream", 32'(mism), 0);
    chk("t4_hold_stable", 32'(stab1), 0);
    chk("t4_stalls_seen", 32'(stall1 > 0), 1);
    chk("t4_reads", 32'(rd1), 256);
    chk("t4_read_order", 32'(bad1), 0);
    chk("t4_done_cnt", 32'(dn1), 1);
    // start while busy and during the done cycle is ignored
    clear();
    go8();
    repeat (10) @(negedge clk);
    b.start = 1;
    @(negedge clk);
    b.start = 0;
    wait_done8(2000);
    b.start = 1;
    @(negedge clk);
    b.start = 0;
    chk("t5_start_in_done", 32'(b.busy), 0);
    repeat (5) @(negedge clk);
    chk("t5_single_done", 32'(dn8), 1);
    chk("t5_len", 32'(s8.size()), 256);
    chk("t5_reads", 32'(rd8), 256);
    // start in the idle cycle right after done is accepted
    clear();
    go8();
    wait_done8(2000);
    @(negedge clk);
    b.start = 1;
    @(negedge clk);
    b.start = 0;
    chk("t5_start_after_done", 32'(b.busy), 1);
    wait_done8(2000);
    @(negedge clk);
    chk("t5_two_dones", 32'(dn8), 2);
    chk("t5_two_streams", 32'(s8.size()), 512);
    chk("t5_read_order", 32'(bad8), 0);
    // reset in the middle of a conversion
    clear();
    go8();
    for (int k = 0; k < 2000 && rd8 < 101; k++) @(negedge clk);
    chk("t6_reached_byte100", 32'(rd8 >= 101), 1);
    rst = 0;
    @(negedge clk);
    chk("t6_rst_outs", 32'({b.busy, b.done, b.mem_rd_en, b.mem_rd_addr, b.bit_valid, b.bit_data, b.bit_last}), 0);
    @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    chk("t6_no_done", 32'(dn8), 0);
    chk("t6_idle", 32'(b.busy), 0);
    clear();
    go8();
    wait_done8(2000);
    @(negedge clk);
    mism = 0;
    for (int k = 0; k < 256; k++) if (s8[k] != 8'(k)) mism++;
    chk("t6_restart_stream", 32'(mism + (s8.size() != 256 ? 1000 : 0)), 0);
    chk("t6_restart_reads", 32'(rd8), 256);
    chk("t6_restart_order", 32'(bad8), 0);
    chk("t6_restart_done", 32'(dn8), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
